// File: rtl/div_pkg.sv
// ============================================================================
// Module  : div_pkg
// Brief   : Shared types and default width for the sequential divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider_if.sv
// ============================================================================
// Module  : seq_divider_if
// Brief   : Request/result bundle between a divider client and the divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module  : div_step
// Brief   : One combinational restoring-division step (shift, trial subtract).
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH:0]   r_i,
    input  wire logic             bit_i,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH:0]   r_o,
    output logic                  q_o
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;
    logic           unused_r_msb;

    // The partial remainder is always below D, so its MSB never survives the shift.
    assign unused_r_msb = r_i[WIDTH];
    assign w_shifted    = {r_i[WIDTH-1:0], bit_i};
    assign w_trial      = w_shifted - {1'b0, d_i};

    always_comb begin
        r_o = w_shifted;
        q_o = 1'b0;
        if (!w_trial[WIDTH]) begin
            r_o = w_trial;
            q_o = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module  : seq_divider
// Brief   : Iterative unsigned restoring divider, one quotient bit per clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input wire logic     clk,
    input wire logic     rst_n,
    seq_divider_if.slave bus
);

    localparam int            CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   w_step_r;
    logic             w_step_bit;
    logic [WIDTH-1:0] w_q_next;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_i   (r_q),
        .bit_i (q_q[WIDTH-1]),
        .d_i   (d_q),
        .r_o   (w_step_r),
        .q_o   (w_step_bit)
    );

    assign w_q_next = {q_q[WIDTH-2:0], w_step_bit};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_d     = bus.dividend;
                    d_d     = bus.divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = (bus.divisor == '0) ? DONE : RUN;
                end
            end

            RUN: begin
                r_d   = w_step_r;
                q_d   = w_q_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    quo_d   = w_q_next;
                    rem_d   = w_step_r[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
                // A zero divisor skips RUN, so its results are published on the way out of DONE.
                if (d_q == '0) begin
                    quo_d  = '1;
                    rem_d  = q_q;
                    dbz_d  = 1'b1;
                    done_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module  : tb_seq_divider
// Brief   : Scoreboard bench for seq_divider at WIDTH=4.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Every done pulse retires the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: done=1 with no outstanding request at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {e.q, e.r, e.z}) begin
                    errors++;
                    $display("FAIL result: got q=%0d r=%0d z=%0b expected q=%0d r=%0d z=%0b",
                             bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
                end
            end
        end
    end

    // Drives start across one accepting edge; returns at the negedge after E0.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", name, bus.done, n);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b q=%0d r=%0d z=%b, required all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_timing();
        launch(4'd13, 4'd3);
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (bus.busy !== (k < 4) || bus.done !== (k == 4)) begin
                errors++;
                $display("FAIL timing_E%0d: busy=%b done=%b, required busy=%b done=%b",
                         k, bus.busy, bus.done, k < 4, k == 4);
            end
        end
    endtask

    task automatic test_values();
        logic [W-1:0] as [3] = '{4'd15, 4'd3, 4'd0};
        logic [W-1:0] bs [3] = '{4'd1, 4'd7, 4'd5};
        for (int i = 0; i < 3; i++) begin
            launch(as[i], bs[i]);
            wait_done("values");
        end
    endtask

    task automatic test_div_zero();
        launch(4'd5, 4'd0);
        for (int k = 0; k <= 2; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0 || bus.done !== (k == 1)) begin
                errors++;
                $display("FAIL divzero_E%0d: busy=%b done=%b, required busy=0 done=%b",
                         k, bus.busy, bus.done, k == 1);
            end
        end
        launch(4'd9, 4'd2);
        wait_done("after_divzero");
    endtask

    task automatic test_ignore_start();
        int pulses;
        pulses = 0;
        launch(4'd14, 4'd4);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd7;
        bus.divisor  = 4'd1;
        @(negedge clk);
        bus.start    = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ignore_start_pulses: got %0d done pulses, required 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int hits[$];
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd11;
        bus.divisor  = 4'd2;
        repeat (3) sb.push_back(model(4'd11, 4'd2));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 12) bus.start = 1'b0;
            if (bus.done === 1'b1) hits.push_back(k);
        end
        checks++;
        if (hits.size() != 3 || hits[0] != 4 || hits[1] != 10 || hits[2] != 16) begin
            errors++;
            $display("FAIL back_to_back: got %0d done pulses first at E%0d, required 3 at E4/E10/E16",
                     hits.size(), (hits.size() > 0) ? hits[0] : -1);
        end
    endtask

    task automatic test_reset_mid_run();
        launch(4'd13, 4'd3);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b q=%0d r=%0d z=%b, required all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: busy=%b done=%b, required 0 0", bus.busy, bus.done);
            end
        end
        launch(4'd8, 4'd3);
        wait_done("after_reset");
    endtask

    task automatic test_exhaustive();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                launch(W'(a), W'(b));
                wait_done("exhaustive");
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_timing();
        test_values();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_divider.md
# seq_divider

Iterative unsigned restoring divider for the arithmetic datapath, built as the inverse companion to the ripple add/subtract units. It accepts a dividend/divisor pair on a start strobe and resolves one quotient bit per clock using a trial subtraction. It reports quotient, remainder and a divide-by-zero flag with a one-cycle done pulse. It sits beside the 4-bit adder/subtractor and shares its operand width.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock; the block's only clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- dividend  in  WIDTH  unsigned numerator, sampled with accepted start
- divisor  in  WIDTH  unsigned denominator, sampled with accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; results valid
- quotient  out  WIDTH  registered quotient
- remainder  out  WIDTH  registered remainder
- div_by_zero  out  1  registered; set when the accepted divisor was 0

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE + start=1 at an edge: latch dividend into the shift register Q and divisor into D; clear the partial remainder R (WIDTH+1 bits) and the step counter.
  - If divisor≠0, go to RUN.
  - If divisor=0, go to DONE with quotient=all-ones, remainder=dividend, div_by_zero=1.
- IDLE + start=0: hold. Outputs keep their last values.
- RUN step, one per edge:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - trial = R' − {0,D}, computed at WIDTH+1 bits.
  - If trial[WIDTH]=0, then R=trial and shift 1 into Q's LSB. Otherwise R=R' and shift 0 into Q's LSB.
  - Q shifts left one bit each step.
- After WIDTH steps, go to DONE. Register quotient=Q, remainder=R[WIDTH-1:0] and div_by_zero=0.
- DONE: done=1 for exactly one cycle, then return to IDLE unconditionally. start is ignored in DONE.
- start in RUN or DONE is ignored and not queued.
- Unsigned only. remainder < divisor always holds when divisor≠0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Internal Q, D, R and counter are also 0.
- Let the accepting edge be E0.
  - For divisor≠0: busy is high from E0 to EW. Steps occur at E1..EW. done, quotient and remainder update at EW. done falls at EW+1.
  - Latency from accepting edge to done is WIDTH cycles; this is 4 at the default.
  - For divisor=0: done and the results update at E1, one cycle after the accepting edge. busy never rises.
- The earliest restart is the edge after done falls, i.e. start sampled in IDLE at EW+1. Throughput is one operation per WIDTH+2 cycles.
- Reset asserted mid-operation: state returns to IDLE immediately, with no done pulse. All outputs return to their reset values.
- Operands may change after E0 without effect.

## Structure
- Package div_pkg: state enum (IDLE, RUN, DONE) and the default WIDTH constant.
- Sub-module div_step: a combinational single restoring step. Inputs are R (WIDTH+1 bits), the incoming bit and D. Outputs are the next R and the quotient bit. Its WIDTH+1-bit subtract is the trial subtractor.
- Top level holds the FSM, a counter of clog2(WIDTH+1) bits, and the Q/D/R registers.

## Test plan
- Accept 13/3 at E0 -> busy high for E0 to E4. At E4: done=1, quotient=4, remainder=1, div_by_zero=0. done=0 at E5.
- Accept 15/1 -> quotient=15, remainder=0. Accept 3/7 -> quotient=0, remainder=3. Accept 0/5 -> quotient=0, remainder=0.
- Accept 5/0 -> done at E1, quotient=15, remainder=5, div_by_zero=1, busy never high. A following 9/2 -> quotient=4, remainder=1, div_by_zero=0.
- Change the operands and pulse start at E2 during a 14/4 run -> result is quotient=3, remainder=2, with exactly one done pulse. Start held high continuously -> back-to-back operations every 6 cycles.
- Drop rst_n at E2 of a run -> outputs and state are zero and IDLE immediately, with no done pulse. After release, a new 8/3 gives quotient=2, remainder=2.
- Exhaustive check over all 256 operand pairs at WIDTH=4 against a reference model, including the divide-by-zero convention.
